// File: rtl/alu_dispatch_pkg.sv
// Shared constants for alu_dispatch: RV32I opcodes, ALU op codes in {funct7[5],funct3} form, FSM states.
// ALU_LATENCY is the external ALU's operand-to-result delay in cycles.
package alu_dispatch_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam int ALU_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_dispatch_regfile.sv
// 32x32 register file: two registered read ports (updated only when rd_en_i), one write port, x0 reads 0.
// Optional combinational debug read port under ALU_DISPATCH_DBG_EN.
module alu_dispatch_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en_i,
  input  logic [4:0]  rs1_addr_i,
  input  logic [4:0]  rs2_addr_i,
  output logic [31:0] rs1_data_o,
  output logic [31:0] rs2_data_o,
  input  logic        wr_en_i,
  input  logic [4:0]  wr_addr_i,
  input  logic [31:0] wr_data_i
`ifdef ALU_DISPATCH_DBG_EN
  ,
  input  logic [4:0]  dbg_addr_i,
  output logic [31:0] dbg_data_o
`endif
);

  logic [31:0] regs_q [32];
  logic [31:0] rs1_data_q;
  logic [31:0] rs2_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else begin
      if (wr_en_i && (wr_addr_i != 5'd0)) regs_q[wr_addr_i] <= wr_data_i;
      if (rd_en_i) begin
        rs1_data_q <= (rs1_addr_i == 5'd0) ? 32'd0 : regs_q[rs1_addr_i];
        rs2_data_q <= (rs2_addr_i == 5'd0) ? 32'd0 : regs_q[rs2_addr_i];
      end
    end
  end

  assign rs1_data_o = rs1_data_q;
  assign rs2_data_o = rs2_data_q;

`ifdef ALU_DISPATCH_DBG_EN
  assign dbg_data_o = (dbg_addr_i == 5'd0) ? 32'd0 : regs_q[dbg_addr_i];
`endif

endmodule

// File: rtl/alu_dispatch.sv
// RV32I OP/OP-IMM dispatcher: IDLE->READ->EXEC->WB, done 3 cycles after accept, one instruction per 4 cycles.
// instr_ready only in IDLE, no queueing; ALU_DISPATCH_DBG_EN adds a combinational register debug read port.
module alu_dispatch
  import alu_dispatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic [31:0] alu_rs1,
  output logic [31:0] alu_rs2,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_rd,
  output logic        done,
  output logic        illegal
`ifdef ALU_DISPATCH_DBG_EN
  ,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
`endif
);

  state_e      state_q, state_d;
  logic [31:0] instr_q;
  logic        illegal_q;
  logic        use_imm_q;
  logic [31:0] imm_q;
  logic [3:0]  alu_op_q;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  logic        dec_illegal;
  logic        dec_use_imm;
  logic [31:0] dec_imm;
  logic [3:0]  dec_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  always_comb begin
    dec_illegal = 1'b1;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    dec_op      = {instr_q[30], funct3};
    case (opcode)
      OPC_OP: begin
        dec_illegal = !((funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        dec_use_imm = 1'b1;
        case (funct3)
          3'b001: begin
            dec_illegal = (funct7 != F7_BASE);
            dec_imm     = {27'd0, instr_q[24:20]};
            dec_op      = ALU_SLL;
          end
          3'b101: begin
            dec_illegal = !((funct7 == F7_BASE) || (funct7 == F7_ALT));
            dec_imm     = {27'd0, instr_q[24:20]};
            dec_op      = {instr_q[30], 3'b101};
          end
          default: begin
            dec_illegal = 1'b0;
            dec_imm     = {{20{instr_q[31]}}, instr_q[31:20]};
            dec_op      = {1'b0, funct3};
          end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = READ;
      end
      READ: state_d = dec_illegal ? WB : EXEC;
      EXEC: state_d = WB;
      WB: begin
        done    = 1'b1;
        illegal = illegal_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand/op registers load only on a legal READ so they stay frozen through WB, IDLE and illegal instructions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      instr_q   <= '0;
      illegal_q <= 1'b0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      alu_op_q  <= ALU_ADD;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && instr_valid) instr_q <= instr;
      if (state_q == READ) begin
        illegal_q <= dec_illegal;
        if (!dec_illegal) begin
          use_imm_q <= dec_use_imm;
          imm_q     <= dec_imm;
          alu_op_q  <= dec_op;
        end
      end
    end
  end

  alu_dispatch_regfile u_regfile (
    .clk        (clk),
    .rst        (rst),
    .rd_en_i    ((state_q == READ) && !dec_illegal),
    .rs1_addr_i (instr_q[19:15]),
    .rs2_addr_i (instr_q[24:20]),
    .rs1_data_o (rs1_data),
    .rs2_data_o (rs2_data),
    .wr_en_i    ((state_q == WB) && !illegal_q),
    .wr_addr_i  (instr_q[11:7]),
    .wr_data_i  (alu_rd)
`ifdef ALU_DISPATCH_DBG_EN
    ,
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
`endif
  );

  assign alu_rs1 = rs1_data;
  assign alu_rs2 = use_imm_q ? imm_q : rs2_data;
  assign alu_op  = alu_op_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: directed RV32I cases plus random instructions against an architectural register model.
// Register state is observed through the ALU operands of later instructions (and the debug port when built in).
module tb_alu_dispatch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic [3:0]  alu_op;
  logic [31:0] alu_rd;
  logic        done;
  logic        illegal;
`ifdef ALU_DISPATCH_DBG_EN
  logic [4:0]  dbg_addr = 5'd0;
  logic [31:0] dbg_data;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] xm [32];
  logic [31:0] last_a, last_b, obs_a, obs_b;
  logic [3:0]  last_op;

  always #5 clk = ~clk;

  alu_dispatch dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_rs1     (alu_rs1),
    .alu_rs2     (alu_rs2),
    .alu_op      (alu_op),
    .alu_rd      (alu_rd),
    .done        (done),
    .illegal     (illegal)
`ifdef ALU_DISPATCH_DBG_EN
    ,
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
`endif
  );

  // RV32I integer semantics by funct3 plus the alternate (SUB/SRA) bit.
  function automatic logic [31:0] rv_arith(input logic [2:0] f3, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    sa = a;
    case (f3)
      3'd0: if (alt) return a - b; else return a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'd0, ($signed(a) < $signed(b))};
      3'd3: return {31'd0, (a < b)};
      3'd4: return a ^ b;
      3'd5: if (alt) return sa >>> b[4:0]; else return a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // External ALU with one cycle of latency.
  always @(posedge clk) alu_rd <= rv_arith(alu_op[2:0], alu_op[3], alu_rs1, alu_rs2);

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Architectural reference: legality, expected operands, op code and result for one instruction.
  function automatic void ref_exec(input logic [31:0] ins, output logic legal, output logic [31:0] a,
                                   output logic [31:0] b, output logic [3:0] op, output logic [31:0] res);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = ins[6:0];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a = xm[ins[19:15]];
    b = '0; op = '0; legal = 1'b0; res = '0;
    if (opc == 7'b0110011) begin
      legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      b     = xm[ins[24:20]];
      op    = {ins[30], f3};
      res   = rv_arith(f3, ins[30], a, b);
    end else if (opc == 7'b0010011) begin
      if ((f3 == 3'd1) || (f3 == 3'd5)) begin
        legal = (f7 == 7'h00) || ((f3 == 3'd5) && (f7 == 7'h20));
        b     = {27'd0, ins[24:20]};
        op    = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
        res   = rv_arith(f3, op[3], a, b);
      end else begin
        legal = 1'b1;
        b     = {{20{ins[31]}}, ins[31:20]};
        op    = {1'b0, f3};
        res   = rv_arith(f3, 1'b0, a, b);
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge of the WB (done) cycle.
  task automatic run_instr(input logic [31:0] ins);
    logic        legal;
    logic [31:0] ea, eb, res;
    logic [3:0]  eop;
    int          guard;
    ref_exec(ins, legal, ea, eb, eop, res);
    guard = 0;
    while (instr_ready !== 1'b1 && guard < 16) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_ready", 32'(instr_ready), 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'($urandom_range(0, 1));
    instr = $urandom;
    chk("busy_ready", 32'(instr_ready), 32'd0);
    chk("read_done", 32'(done), 32'd0);
    @(negedge clk);
    if (legal) begin
      chk("exec_rs1", alu_rs1, ea);
      chk("exec_rs2", alu_rs2, eb);
      chk("exec_op", 32'(alu_op), 32'(eop));
      chk("exec_done", 32'(done), 32'd0);
      obs_a = alu_rs1;
      obs_b = alu_rs2;
      last_a = ea; last_b = eb; last_op = eop;
      instr_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("wb_done", 32'(done), 32'd1);
    chk("wb_illegal", 32'(illegal), 32'(!legal));
    chk("hold_rs1", alu_rs1, last_a);
    chk("hold_rs2", alu_rs2, last_b);
    chk("hold_op", 32'(alu_op), 32'(last_op));
    if (legal && (ins[11:7] != 5'd0)) xm[ins[11:7]] = res;
  endtask

  task automatic probe(input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] ea, input logic [31:0] eb);
    run_instr(enc_r(7'h00, rb, ra, 3'd0, 5'd0));
    chk("probe_a", obs_a, ea);
    chk("probe_b", obs_b, eb);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic [31:0] w;
    f3  = 3'($urandom_range(0, 7));
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    case ($urandom_range(0, 9))
      0, 1, 2, 3:
        return enc_r((((f3 == 3'd0) || (f3 == 3'd5)) && ($urandom_range(0, 1) == 1)) ? 7'h20 : 7'h00,
                     rs2, rs1, f3, rd);
      4, 5, 6, 7: begin
        if (f3 == 3'd1) imm = {7'h00, rs2};
        else if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, rs2};
        else imm = 12'($urandom);
        return enc_i(imm, rs1, f3, rd);
      end
      8: begin
        if ($urandom_range(0, 1) == 1) return enc_r(7'h01, rs2, rs1, f3, rd);
        return enc_r(7'h20, rs2, rs1, ((f3 == 3'd0) || (f3 == 3'd5)) ? 3'd2 : f3, rd);
      end
      default: begin
        w = $urandom;
        if ((w[6:0] == 7'b0110011) || (w[6:0] == 7'b0010011)) w[6:0] = 7'b1100011;
        return w;
      end
    endcase
  endfunction

  initial begin
    logic [1:0]  expv;
    logic [31:0] base;
    for (int r = 0; r < 32; r++) xm[r] = '0;
    last_a = '0; last_b = '0; last_op = '0; obs_a = '0; obs_b = '0;
    rst = 1'b1;
    instr = '0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_rs1", alu_rs1, 32'd0);
    chk("rst_rs2", alu_rs2, 32'd0);
    chk("rst_op", 32'(alu_op), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(instr_ready), 32'd1);

    // Directed RV32I cases
    run_instr(enc_i(12'd4, 5'd0, 3'd0, 5'd1));
    run_instr(enc_i(12'd3, 5'd0, 3'd0, 5'd2));
    probe(5'd1, 5'd2, 32'd4, 32'd3);
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3));
    run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4));
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd5));
    probe(5'd3, 5'd4, 32'd7, 32'd1);
    probe(5'd5, 5'd0, 32'd32, 32'd0);
    run_instr(enc_i(12'hFF0, 5'd0, 3'd0, 5'd1));
    run_instr(enc_i(12'd2, 5'd0, 3'd0, 5'd2));
    run_instr(enc_r(7'h20, 5'd2, 5'd1, 3'd5, 5'd11));
    probe(5'd11, 5'd1, 32'hFFFF_FFFC, 32'hFFFF_FFF0);
    run_instr(enc_i(12'd4, 5'd0, 3'd0, 5'd1));
    run_instr(enc_i(12'hFFF, 5'd1, 3'd2, 5'd6));
    run_instr(enc_i(12'hFFF, 5'd1, 3'd3, 5'd7));
    probe(5'd6, 5'd7, 32'd0, 32'd1);
    run_instr(enc_i(12'd1, 5'd0, 3'd0, 5'd1));
    run_instr(enc_i({7'h00, 5'd31}, 5'd1, 3'd1, 5'd1));
    run_instr(enc_i({7'h20, 5'd1}, 5'd1, 3'd5, 5'd8));
    probe(5'd8, 5'd1, 32'hC000_0000, 32'h8000_0000);
    run_instr(enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0));
    probe(5'd0, 5'd2, 32'd0, 32'd2);
    run_instr({12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011});
    run_instr(enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd12));
    probe(5'd1, 5'd12, 32'h8000_0000, 32'd0);

    // Continuous instr_valid: accepts every 4 cycles, done 3 cycles after each
    base = xm[10];
    instr = enc_i(12'd1, 5'd10, 3'd0, 5'd10);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      expv[1] = (k >= 16) || (k % 4 == 0);
      expv[0] = (k < 16) && (k % 4 == 3);
      chk("stream_rdy_done", 32'({instr_ready, done}), 32'(expv));
      if (k == 0) instr_valid = 1'b1;
      if (k == 15) instr_valid = 1'b0;
    end
    xm[10] = base + 32'd4;
    last_a = base + 32'd3; last_b = 32'd1; last_op = 4'd0;
    probe(5'd10, 5'd0, base + 32'd4, 32'd0);

    for (int i = 0; i < 60; i++) run_instr(rand_instr());
    for (int r = 0; r < 32; r += 2) run_instr(enc_r(7'h00, 5'(r + 1), 5'(r), 3'd0, 5'd0));

`ifdef ALU_DISPATCH_DBG_EN
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      dbg_addr = 5'(r);
      #1;
      chk("dbg_data", dbg_data, xm[r]);
    end
    @(negedge clk);
`endif

    // Reset during EXEC of ADDI x9,x0,5 aborts it and clears all state
    @(negedge clk);
    instr = enc_i(12'd5, 5'd0, 3'd0, 5'd9);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_rs2", alu_rs2, 32'd5);
    rst = 1'b1;
    #1;
    chk("arst_ready", 32'(instr_ready), 32'd1);
    chk("arst_rs1", alu_rs1, 32'd0);
    chk("arst_rs2", alu_rs2, 32'd0);
    chk("arst_op", 32'(alu_op), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("arst_done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_ready", 32'(instr_ready), 32'd1);
    end
    for (int r = 0; r < 32; r++) xm[r] = '0;
    last_a = '0; last_b = '0; last_op = '0;
    probe(5'd9, 5'd0, 32'd0, 32'd0);
    for (int r = 0; r < 32; r += 2) run_instr(enc_r(7'h00, 5'(r + 1), 5'(r), 3'd0, 5'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
